// File: rtl/speck_pkg.sv
// speck_pkg: shared Speck64/128 parameters and key-schedule FSM states.
package speck_pkg;
   localparam int W      = 32;
   localparam int ROUNDS = 27;
   localparam int M      = 4;
   localparam int ALPHA  = 8;
   localparam int BETA   = 3;
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
endpackage

// File: rtl/speck_ks_step.sv
// speck_ks_step: one combinational Speck key-schedule step.
module speck_ks_step #(
   parameter int W     = speck_pkg::W,
   parameter int ALPHA = speck_pkg::ALPHA,
   parameter int BETA  = speck_pkg::BETA
) (
   input  logic [W-1:0] k,
   input  logic [W-1:0] l0,
   input  logic [4:0]   i,
   output logic [W-1:0] k_new,
   output logic [W-1:0] l_new
);
   assign l_new = (k + ((l0 >> ALPHA) | (l0 << (W - ALPHA)))) ^ W'(i);
   assign k_new = ((k << BETA) | (k >> (W - BETA))) ^ l_new;
endmodule

// File: rtl/speck_key_schedule.sv
// speck_key_schedule: expands a Speck master key into a readable round-key table.
module speck_key_schedule import speck_pkg::*; #(
   parameter int W      = speck_pkg::W,
   parameter int ROUNDS = speck_pkg::ROUNDS,
   parameter int M      = speck_pkg::M,
   parameter int ALPHA  = speck_pkg::ALPHA,
   parameter int BETA   = speck_pkg::BETA
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [M*W-1:0] key_in,
   output logic           busy,
   output logic           done,
   output logic           keys_valid,
   input  logic [4:0]     rd_idx,
   output logic [W-1:0]   rd_key
);
   state_t         state, state_nx;
   logic [W-1:0]   k, k_new, l_new;
   logic [W-1:0]   l [M-1];
   logic [4:0]     i;
   logic [W-1:0]   rk [ROUNDS];

   speck_ks_step #(.W(W), .ALPHA(ALPHA), .BETA(BETA)) u_step (
      .k(k), .l0(l[0]), .i(i), .k_new(k_new), .l_new(l_new)
   );

   always_comb begin
      state_nx = state;
      if (state == IDLE && start) state_nx = EXPAND;
      else if (state == EXPAND && i == 5'(ROUNDS - 2)) state_nx = DONE;
      else if (state == DONE) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         i          <= '0;
         k          <= '0;
         keys_valid <= 1'b0;
         for (int n = 0; n < M-1; n++) l[n] <= '0;
         for (int n = 0; n < ROUNDS; n++) rk[n] <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            k          <= key_in[W-1:0];
            rk[0]      <= key_in[W-1:0];
            i          <= '0;
            keys_valid <= 1'b0;
            for (int n = 0; n < M-1; n++) l[n] <= key_in[W*(n+1) +: W];
         end else if (state == EXPAND) begin
            k            <= k_new;
            rk[i + 5'd1] <= k_new;
            i            <= i + 5'd1;
            for (int n = 0; n < M-2; n++) l[n] <= l[n+1];
            l[M-2] <= l_new;
            // flag valid together with the done pulse
            if (state_nx == DONE) keys_valid <= 1'b1;
         end
      end
   end

   assign busy   = state != IDLE;
   assign done   = state == DONE;
   assign rd_key = (32'(rd_idx) < ROUNDS) ? rk[rd_idx] : '0;
endmodule

// File: tb/tb_speck_key_schedule.sv
// tb_speck_key_schedule: directed checks of the Speck64/128 key schedule.
module tb_speck_key_schedule;
   localparam int R = 27;
   localparam logic [127:0] KEY = 128'h1b1a1918_13121110_0b0a0908_03020100;

   logic         clk = 1'b0;
   logic         rst_n, start, busy, done, keys_valid;
   logic [127:0] key_in;
   logic [4:0]   rd_idx;
   logic [31:0]  rd_key;
   logic [31:0]  exp_rk [R];
   int           checks = 0;
   int           errors = 0;

   speck_key_schedule dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
      .done(done), .keys_valid(keys_valid), .rd_idx(rd_idx), .rd_key(rd_key)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ror(input logic [31:0] v, input int s);
      return (v >> s) | (v << (32 - s));
   endfunction

   function automatic logic [31:0] rol(input logic [31:0] v, input int s);
      return (v << s) | (v >> (32 - s));
   endfunction

   task automatic build_model(input logic [127:0] key);
      logic [31:0] k, l0, l1, l2, ln;
      {l2, l1, l0, k} = key;
      exp_rk[0] = k;
      for (int n = 0; n < R - 1; n++) begin
         ln = (k + ror(l0, 8)) ^ 32'(n);
         k  = rol(k, 3) ^ ln;
         l0 = l1; l1 = l2; l2 = ln;
         exp_rk[n+1] = k;
      end
   endtask

   // pulse start (or hold it for hold_cycles) and watch 30 cycles of outcome
   task automatic run(input logic [127:0] key, input int hold_cycles,
                      output int first_done, output int pulses);
      key_in = key;
      start  = 1'b1;
      tick;
      first_done = -1;
      pulses     = 0;
      for (int n = 1; n <= 30; n++) begin
         if (n == 5) key_in = ~key;
         if (n >= hold_cycles) start = 1'b0;
         tick;
         if (done) begin
            pulses++;
            if (first_done < 0) first_done = n;
         end
      end
      start = 1'b0;
   endtask

   task automatic check_table(input string name);
      int bad = 0;
      for (int n = 0; n < R; n++) begin
         rd_idx = 5'(n);
         #1;
         if (rd_key !== exp_rk[n]) begin
            bad++;
            $display("FAIL %s rk[%0d]: got %h expected %h", name, n, rd_key, exp_rk[n]);
         end
      end
      checks++;
      if (bad != 0) errors++;
   endtask

   task automatic check_word(input string name, input logic [4:0] idx, input logic [31:0] exp);
      rd_idx = idx;
      #1;
      checks++;
      if (rd_key !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, rd_key, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0;
      tick; tick;
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);
      check_bit("reset_valid", keys_valid, 1'b0);
      check_word("reset_rk0", 5'd0, 32'h0);
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_expand;
      int fd, p;
      key_in = KEY;
      start  = 1'b1;
      tick;
      start = 1'b0;
      check_bit("expand_busy", busy, 1'b1);
      check_word("expand_rk0_at_start", 5'd0, 32'h03020100);
      tick;
      check_word("expand_rk1_next", 5'd1, 32'h131d0309);
      fd = -1; p = 0;
      for (int n = 2; n <= 30; n++) begin
         tick;
         if (done) begin
            p++;
            if (fd < 0) fd = n;
         end
      end
      checks++;
      if (fd != R - 1) begin
         errors++;
         $display("FAIL done_latency: got %0d expected %0d", fd, R - 1);
      end
      checks++;
      if (p != 1) begin
         errors++;
         $display("FAIL done_pulses: got %0d expected 1", p);
      end
      check_bit("expand_valid", keys_valid, 1'b1);
      check_bit("expand_idle", busy, 1'b0);
      build_model(KEY);
      check_table("expand_table");
   endtask

   task automatic test_decrypt;
      logic [31:0] x, y;
      x = 32'h8c6fa548;
      y = 32'h454e028b;
      for (int n = R - 1; n >= 0; n--) begin
         rd_idx = 5'(n);
         #1;
         y = ror(y ^ x, 3);
         x = rol((x ^ rd_key) - y, 8);
      end
      checks++;
      if ({x, y} !== 64'h3b726574_7475432d) begin
         errors++;
         $display("FAIL decrypt_pt: got %h%h expected 3b7265747475432d", x, y);
      end
   endtask

   task automatic test_held_start;
      int fd, p;
      run(KEY, 20, fd, p);
      checks++;
      if (p != 1) begin
         errors++;
         $display("FAIL held_start_pulses: got %0d expected 1", p);
      end
      build_model(KEY);
      check_table("held_start_table");
   endtask

   task automatic test_mid_reset;
      int fd, p;
      key_in = 128'h0;
      start  = 1'b1;
      tick;
      start = 1'b0;
      for (int n = 0; n < 10; n++) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check_bit("midrst_busy", busy, 1'b0);
      check_bit("midrst_valid", keys_valid, 1'b0);
      for (int n = 0; n < R; n++) exp_rk[n] = 32'h0;
      check_table("midrst_cleared");
      run(KEY, 1, fd, p);
      build_model(KEY);
      check_table("midrst_rerun");
      check_bit("midrst_rerun_valid", keys_valid, 1'b1);
   endtask

   task automatic test_rd_bounds;
      check_word("rd_idx27", 5'd27, 32'h0);
      check_word("rd_idx31", 5'd31, 32'h0);
   endtask

   task automatic test_all_ones;
      int fd, p;
      run({128{1'b1}}, 1, fd, p);
      check_word("ones_rk1", 5'd1, 32'h00000001);
      build_model({128{1'b1}});
      check_table("ones_table");
   endtask

   task automatic test_restart_zero;
      int fd, p;
      check_bit("restart_valid_before", keys_valid, 1'b1);
      key_in = 128'h0;
      start  = 1'b1;
      tick;
      start = 1'b0;
      check_bit("restart_valid_drop", keys_valid, 1'b0);
      check_word("restart_rk0", 5'd0, 32'h0);
      for (int n = 0; n < 30; n++) tick;
      check_bit("restart_valid_back", keys_valid, 1'b1);
      check_word("restart_rk2", 5'd2, 32'h00000001);
   endtask

   initial begin
      test_reset;
      test_expand;
      test_decrypt;
      test_held_start;
      test_mid_reset;
      test_rd_bounds;
      test_all_ones;
      test_restart_zero;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
